// File: rtl/seq_gen_tx.sv
// Serial pattern transmitter: shifts a captured pattern out MSB first, repeated
// back to back. Optional single-cycle gap between copies via SEQ_GEN_TX_GAP_EN.
module seq_gen_tx #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern,
   input  logic [CNT_W-1:0] repeat_cnt,
   output logic             outbits,
   output logic             valid,
   output logic             busy,
   output logic             done
);

   // state   | meaning
   // S_IDLE  | waiting for start, all outputs low
   // S_SHIFT | driving shift_q MSB as a valid pattern bit
   // S_GAP   | one idle bit between copies (gap build only)
   // S_DONE  | single-cycle done pulse, then back to idle
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
`ifdef SEQ_GEN_TX_GAP_EN
      ,
      S_GAP   = 2'd3
`endif
   } state_t;

   localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);
   localparam logic [CNT_W-1:0] REPS_ONE = CNT_W'(1);

   state_t           state_q, state_d;
   logic [PAT_W-1:0] shift_q, shift_d;
   logic [PAT_W-1:0] copy_q,  copy_d;
   logic [CNT_W-1:0] reps_q,  reps_d;
   logic [IDX_W-1:0] idx_q,   idx_d;

   logic last_bit;
   logic more_copies;

   assign last_bit    = (idx_q == '0);
   assign more_copies = (reps_q > REPS_ONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         shift_q <= '0;
         copy_q  <= '0;
         reps_q  <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         copy_q  <= copy_d;
         reps_q  <= reps_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_SHIFT;
         end
         S_SHIFT: begin
            if (last_bit) begin
               if (more_copies) begin
`ifdef SEQ_GEN_TX_GAP_EN
                  state_d = S_GAP;
`else
                  state_d = S_SHIFT;
`endif
               end else begin
                  state_d = S_DONE;
               end
            end
         end
`ifdef SEQ_GEN_TX_GAP_EN
         S_GAP:   state_d = S_SHIFT;
`endif
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath next-state; the copy is reloaded on the last bit so the next
   // copy's MSB is ready in the following SHIFT (or after the GAP).
   always_comb begin
      shift_d = shift_q;
      copy_d  = copy_q;
      reps_d  = reps_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               shift_d = pattern;
               copy_d  = pattern;
               reps_d  = (repeat_cnt == '0) ? REPS_ONE : repeat_cnt;
               idx_d   = IDX_LAST;
            end
         end
         S_SHIFT: begin
            if (last_bit) begin
               if (more_copies) begin
                  reps_d  = reps_q - REPS_ONE;
                  shift_d = copy_q;
                  idx_d   = IDX_LAST;
               end
            end else begin
               shift_d = {shift_q[PAT_W-2:0], 1'b0};
               idx_d   = idx_q - IDX_W'(1);
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      outbits = 1'b0;
      valid   = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         S_SHIFT: begin
            outbits = shift_q[PAT_W-1];
            valid   = 1'b1;
            busy    = 1'b1;
         end
`ifdef SEQ_GEN_TX_GAP_EN
         S_GAP:   busy = 1'b1;
`endif
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: doc/seq_gen_tx.md
SEQ_GEN_TX -- requirements
Module: seq_gen_tx

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and reset.
REQ-002 Parameter PAT_W, default 4: pattern width in bits, legal range 2..16.
REQ-003 Parameter CNT_W, default 4: width of the repeat count.
REQ-004 Port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous active-high reset.
REQ-006 Port start, input, 1 bit: request to transmit; sampled only in IDLE.
REQ-007 Port pattern, input, PAT_W bits: pattern to send, MSB first; sampled with start.
REQ-008 Port repeat_cnt, input, CNT_W bits: number of back-to-back pattern copies; sampled with start.
REQ-009 Port outbits, output, 1 bit: serial bit stream, intended to drive the inbits input of the sequence detector.
REQ-010 Port valid, output, 1 bit: outbits carries a pattern bit this cycle.
REQ-011 Port busy, output, 1 bit: transmission in progress.
REQ-012 Port done, output, 1 bit: one-cycle pulse at the end of a transmission.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT, GAP and DONE; all outputs SHALL be Moore outputs, decoded from state and registers only.
REQ-014 IDLE: outbits=0, valid=0, busy=0, done=0.
REQ-015 IDLE with start=1 at edge k: capture pattern into the shift register and a pattern copy register; load reps=repeat_cnt (0 treated as 1); load bit_idx=PAT_W-1; enter SHIFT after edge k.
REQ-016 SHIFT: outbits=shift_reg[PAT_W-1], valid=1, busy=1; each edge shifts left by one and decrements bit_idx.
REQ-017 SHIFT with bit_idx=0 and reps>1: decrement reps, reload the shift register from the copy, reset bit_idx to PAT_W-1; next state is SHIFT, or GAP when the gap feature is compiled in.
REQ-018 SHIFT with bit_idx=0 and reps<=1: enter DONE.
REQ-019 GAP: exactly one cycle with outbits=0, valid=0, busy=1; then SHIFT.
REQ-020 DONE: exactly one cycle with done=1, busy=0, valid=0, outbits=0; then IDLE.
REQ-021 The first pattern bit SHALL appear on outbits in the cycle after start is sampled, i.e. latency of 1 clock.
REQ-022 Total SHIFT cycles SHALL equal PAT_W*max(repeat_cnt,1); with no gap, copies SHALL be contiguous with no idle bit between them.
REQ-023 start while in SHIFT, GAP or DONE SHALL be ignored; changes to pattern or repeat_cnt after capture SHALL have no effect.
REQ-024 start held high continuously SHALL begin a new transmission on the first IDLE cycle after DONE.
REQ-025 repeat_cnt=2^CNT_W-1 SHALL produce exactly that many copies, with no counter wrap.

Reset
REQ-026 reset=1 at a clock edge SHALL force IDLE and clear the shift register, the copy register, reps and bit_idx; outbits, valid, busy and done SHALL all be 0 in the following cycle.
REQ-027 reset SHALL take priority over start and over any state transition, including mid-SHIFT and in GAP; the aborted transmission SHALL not produce a done pulse.

Configuration
REQ-028 The gap feature SHALL be controlled by the macro SEQ_GEN_TX_GAP_EN.
REQ-029 With SEQ_GEN_TX_GAP_EN defined: one GAP cycle (outbits=0, valid=0) is inserted between consecutive copies; there is no gap before the first copy or after the last.
REQ-030 Without SEQ_GEN_TX_GAP_EN: the GAP state and its logic are absent, and copies are contiguous.

Verification
REQ-031 PAT_W=4, pattern=1011, repeat_cnt=1, start pulse: outbits 1,0,1,1 with valid=1 for 4 cycles, then done=1 for 1 cycle, then IDLE.
REQ-032 pattern=1011, repeat_cnt=3, no gap: outbits 101110111011 over 12 contiguous valid cycles; exactly one done pulse.
REQ-033 repeat_cnt=0: output identical to repeat_cnt=1 (4 bits, one done).
REQ-034 Second start pulse and a pattern change issued during SHIFT: stream unchanged; exactly one done pulse.
REQ-035 reset asserted on the third SHIFT cycle of 1011: next cycle outbits=0, valid=0, busy=0; no done pulse; a new start then behaves as in REQ-031.
REQ-036 SEQ_GEN_TX_GAP_EN defined, pattern=1011, repeat_cnt=2: valid sequence 1,1,1,1,0,1,1,1,1 and outbits 1,0,1,1,0,1,0,1,1; the stream drives seq_detect_ov and its detect output is checked against the expected pattern occurrences.
